// File: rtl/cluster_dma_req_arbiter.sv
// Round-robin arbiter feeding the cluster DMA external-request port.
// Requester descriptors are funnelled into one registered descriptor stream.
// An order FIFO routes each in-order DMA completion back to its issuer.
// The number of accepted-but-not-completed transfers is capped at MaxOutstanding.
module cluster_dma_req_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         descr_t        = logic,
  parameter int unsigned IdxWidth       = $clog2(NumReq),
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  descr_t [NumReq-1:0]     req_descr_i,
  output logic [NumReq-1:0]       rsp_valid_o,
  output logic                    dma_req_valid_o,
  input  logic                    dma_req_ready_i,
  output descr_t                  dma_req_o,
  input  logic                    dma_rsp_valid_i,
  output logic [CntWidth-1:0]     outstanding_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned         PtrWidth = $clog2(MaxOutstanding);
  localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxOutstanding);
  localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(NumReq - 1);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e          slot_q;
  descr_t               dma_req_q;
  logic [IdxWidth-1:0]  rr_q;
  logic [CntWidth-1:0]  outstanding_q;
  logic                 err_q;
  logic [NumReq-1:0]    rsp_q, rsp_d;

  logic [IdxWidth-1:0]  fifo_mem [MaxOutstanding];
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;

  logic                 any_valid;
  logic [IdxWidth-1:0]  winner;
  logic                 slot_free;
  logic                 fifo_nonempty;
  logic                 pop;
  logic                 can_accept;
  logic                 accept;

  // The order FIFO holds exactly the outstanding transfers, so the counter doubles as its fill level.
  assign fifo_nonempty = (outstanding_q != '0);
  assign pop           = dma_rsp_valid_i & fifo_nonempty;
  assign slot_free     = (slot_q == SLOT_EMPTY) | dma_req_ready_i;
  // A completion popping this cycle frees a credit for a same-cycle accept.
  assign can_accept    = slot_free & ((outstanding_q < MaxCnt) | pop);
  assign accept        = any_valid & can_accept;

  // Round-robin search: first valid requester at or after rr_q, wrapping around.
  always_comb begin
    int unsigned cand;
    // NOTE: always_comb uses blocking assignments with defaults first so no latch is inferred.
    any_valid = 1'b0;
    winner    = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
      if (!any_valid && req_valid_i[IdxWidth'(cand)]) begin
        any_valid = 1'b1;
        winner    = IdxWidth'(cand);
      end
    end
  end

  // Only the round-robin winner sees ready, and only when a slot and a credit are available.
  always_comb begin
    req_ready_o = '0;
    if (any_valid) begin
      req_ready_o[winner] = can_accept;
    end
  end

  // Output slot FSM: EMPTY -> FULL on accept; FULL reloads on accept or drains when taken.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q    <= SLOT_EMPTY;
      dma_req_q <= '0;
    end else begin
      case (slot_q)
        SLOT_EMPTY: begin
          if (accept) begin
            slot_q    <= SLOT_FULL;
            dma_req_q <= req_descr_i[winner];
          end
        end
        SLOT_FULL: begin
          if (accept) begin
            dma_req_q <= req_descr_i[winner];
          end else if (dma_req_ready_i) begin
            slot_q <= SLOT_EMPTY;
          end
        end
        default: slot_q <= SLOT_EMPTY;
      endcase
    end
  end

  // Round-robin pointer moves just past the winner on every accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (accept) begin
      rr_q <= (winner == LastIdx) ? '0 : winner + 1'b1;
    end
  end

  // Order FIFO storage: records the issuing requester of each accepted transfer.
  // NOTE: the storage array is not reset; the pointers and counter alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_mem[wr_ptr_q] <= winner;
    end
  end

  // Order FIFO pointers; power-of-two depth lets them wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Completion routing: one-hot pulse to the requester at the FIFO head.
  always_comb begin
    rsp_d = '0;
    if (pop) begin
      rsp_d[fifo_mem[rd_ptr_q]] = 1'b1;
    end
  end

  // Outstanding counter, registered completion pulse and sticky spurious-completion flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      rsp_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
      rsp_q <= rsp_d;
      if (dma_rsp_valid_i && !fifo_nonempty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign dma_req_valid_o = (slot_q == SLOT_FULL);
  assign dma_req_o       = dma_req_q;
  assign rsp_valid_o     = rsp_q;
  assign outstanding_o   = outstanding_q;
  assign busy_o          = (outstanding_q != '0);
  assign err_o           = err_q;

endmodule

// File: tb/tb_cluster_dma_req_arbiter.sv
// Self-checking bench for cluster_dma_req_arbiter: per-cycle vector records plus
// a scoreboard that checks descriptor order at the DMA handshake and completion routing.
module tb_cluster_dma_req_arbiter;

  typedef logic [15:0] descr_t;

  typedef struct {
    logic [3:0] valid;
    logic       dready;
    logic       drsp;
    logic [3:0] exp_ready;  // combinational ready during the cycle
    logic       exp_dval;   // dma_req_valid_o after the edge
    logic [3:0] exp_rsp;    // rsp_valid_o after the edge
    logic [3:0] exp_out;    // outstanding_o after the edge
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  descr_t [3:0] req_descr;
  logic [3:0]   rsp_valid;
  logic         dval;
  logic         dready;
  descr_t       dreq;
  logic         drsp;
  logic [3:0]   outst;
  logic         busy;
  logic         err;

  always #5 clk = ~clk;

  cluster_dma_req_arbiter #(
    .NumReq         (4),
    .MaxOutstanding (8),
    .descr_t        (descr_t)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_descr_i     (req_descr),
    .rsp_valid_o     (rsp_valid),
    .dma_req_valid_o (dval),
    .dma_req_ready_i (dready),
    .dma_req_o       (dreq),
    .dma_rsp_valid_i (drsp),
    .outstanding_o   (outst),
    .busy_o          (busy),
    .err_o           (err)
  );

  int     total = 0;
  int     bad   = 0;
  int     seq   = 0;
  bit     count_en = 1'b0;
  int     grant_cnt [4];
  descr_t last_push;
  descr_t a_val;
  descr_t exp_descr_q [$];
  int     exp_idx_q [$];
  vec_t   tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] valid, input logic dr, input logic rs,
                              input logic [3:0] er, input logic dv, input logic [3:0] ersp,
                              input logic [3:0] out);
    vec_t v;
    v.valid = valid; v.dready = dr; v.drsp = rs;
    v.exp_ready = er; v.exp_dval = dv; v.exp_rsp = ersp; v.exp_out = out;
    return v;
  endfunction

  function automatic int oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // One clock cycle: entered just after a rising edge, returns just after the next one.
  task automatic cyc(input vec_t v, input string name);
    int w;
    req_valid = v.valid;
    dready    = v.dready;
    drsp      = v.drsp;
    seq++;
    for (int i = 0; i < 4; i++) req_descr[i] = {4'(i), 12'(seq)};
    #1;
    check({name, " ready"}, 32'(req_ready), 32'(v.exp_ready));
    if (count_en) for (int i = 0; i < 4; i++) if (req_ready[i] && req_valid[i]) grant_cnt[i]++;
    if (v.exp_ready != 4'b0) begin
      w = oh2idx(v.exp_ready);
      last_push = req_descr[w];
      exp_descr_q.push_back(req_descr[w]);
      exp_idx_q.push_back(w);
    end
    @(posedge clk); #1;
    check({name, " dma_valid"},   32'(dval),  32'(v.exp_dval));
    check({name, " rsp_valid"},   32'(rsp_valid), 32'(v.exp_rsp));
    check({name, " outstanding"}, 32'(outst), 32'(v.exp_out));
    check({name, " busy"},        32'(busy),  32'(v.exp_out != 4'd0));
  endtask

  // Scoreboard consumer: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (dval && dready) begin
        if (exp_descr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_descr: unexpected descriptor %0h, none expected", dreq);
        end else begin
          check("sb_descr", 32'(dreq), 32'(exp_descr_q.pop_front()));
        end
      end
      if (rsp_valid != 4'b0) begin
        if (exp_idx_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_rsp: unexpected pulse %b, none expected", rsp_valid);
        end else begin
          check("sb_rsp", 32'(rsp_valid), 32'(4'b1 << exp_idx_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; dready = 1'b0; drsp = 1'b0; req_descr = '0;
    for (int i = 0; i < 4; i++) grant_cnt[i] = 0;

    // Fairness from reset: all valid, DMA always ready, completion one cycle after accept.
    for (int k = 0; k < 8; k++)
      tbl[k] = mk(4'hF, 1'b1, (k != 0), 4'(1 << (k % 4)), 1'b1,
                  (k == 0) ? 4'b0 : 4'(1 << ((k - 1) % 4)), 4'd1);
    tbl[8]  = mk(4'h0, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1000, 4'd0);
    // Single request from requester 2, completion four cycles after issue.
    tbl[9]  = mk(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'd1);
    tbl[10] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd1);
    tbl[11] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd1);
    tbl[12] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd1);
    tbl[13] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd1);
    tbl[14] = mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0100, 4'd0);
    tbl[15] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd0);

    // Reset values.
    #3;
    check("reset dma_valid",   32'(dval),  32'd0);
    check("reset dma_req",     32'(dreq),  32'd0);
    check("reset ready",       32'(req_ready), 32'd0);
    check("reset rsp_valid",   32'(rsp_valid), 32'd0);
    check("reset outstanding", 32'(outst), 32'd0);
    check("reset busy",        32'(busy),  32'd0);
    check("reset err",         32'(err),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    count_en = 1'b1;
    for (int k = 0; k < 9; k++) cyc(tbl[k], $sformatf("fair%0d", k));
    count_en = 1'b0;
    for (int i = 0; i < 4; i++) check($sformatf("fair grants req%0d", i), 32'(grant_cnt[i]), 32'd2);
    for (int k = 9; k < 16; k++) cyc(tbl[k], $sformatf("single%0d", k - 9));

    // Backpressure: descriptor A held while the DMA stalls, then taken with a same-cycle accept.
    cyc(mk(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0, 4'd1), "bp_a");
    a_val = last_push;
    check("bp a loaded", 32'(dreq), 32'(a_val));
    for (int k = 0; k < 5; k++) begin
      cyc(mk(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0, 4'd1), $sformatf("bp_stall%0d", k));
      check($sformatf("bp_stall%0d stable", k), 32'(dreq), 32'(a_val));
    end
    cyc(mk(4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0, 4'd2), "bp_release");
    check("bp b loaded", 32'(dreq), 32'(last_push));
    cyc(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd2), "bp_drain");
    cyc(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'd1), "bp_cpl0");
    cyc(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0010, 4'd0), "bp_cpl1");

    // Credit limit: eight accepts with no completions, then stall, then completion-enabled accept.
    for (int k = 0; k < 8; k++)
      cyc(mk(4'hF, 1'b1, 1'b0, 4'(1 << ((k + 2) % 4)), 1'b1, 4'b0, 4'(k + 1)), $sformatf("credit%0d", k));
    cyc(mk(4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd8), "credit_full");
    cyc(mk(4'hF, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100, 4'd8), "credit_swap");
    cyc(mk(4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd8), "credit_idle");
    for (int k = 0; k < 8; k++)
      cyc(mk(4'h0, 1'b1, 1'b1, 4'b0000, 1'b0, 4'(1 << ((k + 3) % 4)), 4'(7 - k)), $sformatf("credit_cpl%0d", k));

    // Ordering: requesters 3,1,3,0 complete in issue order.
    cyc(mk(4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b0, 4'd1), "ord_iss0");
    cyc(mk(4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0, 4'd2), "ord_iss1");
    cyc(mk(4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b0, 4'd3), "ord_iss2");
    cyc(mk(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0, 4'd4), "ord_iss3");
    cyc(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1000, 4'd3), "ord_cpl0");
    cyc(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0010, 4'd2), "ord_cpl1");
    cyc(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1000, 4'd1), "ord_cpl2");
    cyc(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'd0), "ord_cpl3");

    // Spurious completion with nothing outstanding: sticky error.
    cyc(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'd0), "spur");
    check("spur err set", 32'(err), 32'd1);
    cyc(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd0), "spur_idle");
    check("spur err sticky", 32'(err), 32'd1);
    check("sb descr drained", 32'(exp_descr_q.size()), 32'd0);
    check("sb rsp drained",   32'(exp_idx_q.size()),   32'd0);

    // Reset mid-traffic: outputs return to reset values without waiting for an edge.
    cyc(mk(4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0, 4'd1), "rst_pre0");
    cyc(mk(4'hF, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0, 4'd2), "rst_pre1");
    req_valid = 4'b0; dready = 1'b0; drsp = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("midrst dma_valid",   32'(dval),  32'd0);
    check("midrst dma_req",     32'(dreq),  32'd0);
    check("midrst ready",       32'(req_ready), 32'd0);
    check("midrst rsp_valid",   32'(rsp_valid), 32'd0);
    check("midrst outstanding", 32'(outst), 32'd0);
    check("midrst busy",        32'(busy),  32'd0);
    check("midrst err",         32'(err),   32'd0);
    exp_descr_q.delete();
    exp_idx_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    cyc(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'd0), "post_rst_spur");
    check("post_rst err set", 32'(err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
